// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_pkg
//  Purpose  : Shared constants for the raster timing generator. This covers
//             the default horizontal timing, the bit positions in the
//             vertical sync PROM, and the line mask for the interrupt.
//  Revision : 1.0  initial release
// ============================================================================
package video_timing_pkg;

   // Default horizontal timing, in pixel clocks
   localparam int H_TOTAL_DEFAULT       = 384;
   localparam int H_BLANK_START_DEFAULT = 256;
   localparam int HSYNC_START_DEFAULT   = 296;
   localparam int HSYNC_END_DEFAULT     = 328;

   // Bit positions within the 4-bit vertical sync PROM word
   localparam int VPROM_VBLANK = 2;
   localparam int VPROM_VSYNC  = 1;
   localparam int VPROM_AUX    = 0;

   // An interrupt is raised on lines whose low six bits are all zero
   localparam logic [5:0] IRQ_LINE_MASK = 6'h3f;

   // The PROM is addressed one line ahead, so its data is ready at line wrap
   function automatic logic [7:0] vprom_addr(input logic [7:0] line);
      return line + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_if
//  Purpose  : Timing bundle between the raster generator (master) and its
//             PROM, CPU and video consumers (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface video_timing_if
   import video_timing_pkg::*;
   ;
   logic       ce;
   logic       irq_ack;
   logic [3:0] vprom_d;
   logic [7:0] vprom_a;
   logic [8:0] hcount;
   logic [7:0] vcount;
   logic       hblank;
   logic       hsync;
   logic       vblank;
   logic       vsync;
   logic       vaux;
   logic       blank;
   logic       frame_start;
   logic       irq;

   modport master (
      input  ce, irq_ack, vprom_d,
      output vprom_a, hcount, vcount, hblank, hsync, vblank, vsync, vaux,
             blank, frame_start, irq
   );

   modport slave (
      output ce, irq_ack, vprom_d,
      input  vprom_a, hcount, vcount, hblank, hsync, vblank, vsync, vaux,
             blank, frame_start, irq
   );

endinterface
`default_nettype wire

// File: rtl/video_hcounter.sv
`default_nettype none
// ============================================================================
//  Module   : video_hcounter
//  Purpose  : Pixel column counter with registered hblank/hsync. It also
//             produces a line-wrap strobe on the last enabled column.
//  Revision : 1.0  initial release
// ============================================================================
module video_hcounter
   import video_timing_pkg::*;
#(
   parameter int H_TOTAL       = H_TOTAL_DEFAULT,
   parameter int H_BLANK_START = H_BLANK_START_DEFAULT,
   parameter int HSYNC_START   = HSYNC_START_DEFAULT,
   parameter int HSYNC_END     = HSYNC_END_DEFAULT
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_ce,
   output logic [8:0]      o_hcount,
   output logic            o_hblank,
   output logic            o_hsync,
   output logic            o_line_wrap
);

   // hcount is nine bits wide, so a line can be at most 512 columns
   if (H_TOTAL > 512 || H_TOTAL < 2) begin : g_htotal_check
      $error("video_hcounter: H_TOTAL must be in 2..512");
   end

   // Ten-bit compares let the boundary constants equal 512 without wrapping
   localparam logic [8:0] c_h_last     = 9'(H_TOTAL - 1);
   localparam logic [9:0] c_hb_start   = 10'(H_BLANK_START);
   localparam logic [9:0] c_hs_start   = 10'(HSYNC_START);
   localparam logic [9:0] c_hs_end     = 10'(HSYNC_END);

   logic [8:0] r_hcount;
   logic       r_hblank;
   logic       r_hsync;
   logic       w_last;
   logic [8:0] w_hnext;
   logic [9:0] w_hnext_x;

   assign w_last      = (r_hcount == c_h_last);
   assign w_hnext     = w_last ? 9'd0 : r_hcount + 9'd1;
   assign w_hnext_x   = {1'b0, w_hnext};
   assign o_line_wrap = i_ce & w_last;

   // hblank/hsync are decoded from the next column, so they line up with hcount
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcount <= 9'd0;
         r_hblank <= 1'b0;
         r_hsync  <= 1'b0;
      end else if (i_ce) begin
         r_hcount <= w_hnext;
         r_hblank <= (w_hnext_x >= c_hb_start);
         r_hsync  <= (w_hnext_x >= c_hs_start) && (w_hnext_x < c_hs_end);
      end
   end

   assign o_hcount = r_hcount;
   assign o_hblank = r_hblank;
   assign o_hsync  = r_hsync;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Purpose  : Raster timing generator. It counts lines, addresses the
//             vertical sync PROM one line ahead and latches its output at
//             line wrap. It also produces frame_start and a line-based IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_TOTAL       = H_TOTAL_DEFAULT,
   parameter int H_BLANK_START = H_BLANK_START_DEFAULT,
   parameter int HSYNC_START   = HSYNC_START_DEFAULT,
   parameter int HSYNC_END     = HSYNC_END_DEFAULT
) (
   input  wire logic      clk,
   input  wire logic      reset,
   video_timing_if.master vt
);

   logic [8:0] w_hcount;
   logic       w_hblank;
   logic       w_hsync;
   logic       w_line_wrap;
   logic [7:0] w_vnext;
   logic       w_irq_set;
   logic       w_unused;

   logic [7:0] r_vcount;
   logic       r_vblank;
   logic       r_vsync;
   logic       r_vaux;
   logic       r_irq;

   video_hcounter #(
      .H_TOTAL       (H_TOTAL),
      .H_BLANK_START (H_BLANK_START),
      .HSYNC_START   (HSYNC_START),
      .HSYNC_END     (HSYNC_END)
   ) u_hcounter (
      .clk         (clk),
      .rst         (reset),
      .i_ce        (vt.ce),
      .o_hcount    (w_hcount),
      .o_hblank    (w_hblank),
      .o_hsync     (w_hsync),
      .o_line_wrap (w_line_wrap)
   );

   // PROM word bit 3 carries nothing for this board
   assign w_unused  = vt.vprom_d[3];

   assign w_vnext   = vprom_addr(r_vcount);
   assign w_irq_set = w_line_wrap && ((w_vnext[5:0] & IRQ_LINE_MASK) == 6'd0);

   // Advance the line and capture the PROM word for the line being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vcount <= 8'd0;
         r_vblank <= 1'b0;
         r_vsync  <= 1'b0;
         r_vaux   <= 1'b0;
      end else if (w_line_wrap) begin
         r_vcount <= w_vnext;
         r_vblank <= vt.vprom_d[VPROM_VBLANK];
         r_vsync  <= vt.vprom_d[VPROM_VSYNC];
         r_vaux   <= vt.vprom_d[VPROM_AUX];
      end
   end

   // Interrupt request; a new set outranks a simultaneous acknowledge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else if (w_irq_set) begin
         r_irq <= 1'b1;
      end else if (vt.irq_ack) begin
         r_irq <= 1'b0;
      end
   end

   assign vt.vprom_a     = w_vnext;
   assign vt.hcount      = w_hcount;
   assign vt.vcount      = r_vcount;
   assign vt.hblank      = w_hblank;
   assign vt.hsync       = w_hsync;
   assign vt.vblank      = r_vblank;
   assign vt.vsync       = r_vsync;
   assign vt.vaux        = r_vaux;
   assign vt.blank       = w_hblank | r_vblank;
   assign vt.frame_start = w_line_wrap & (r_vcount == 8'hff);
   assign vt.irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Purpose  : Self-checking bench. Instance A runs the default 384-column
//             timing. Instance B runs a 40-column line so that a full frame
//             fits in a short run. Stimulus pushes expected values into a
//             queue, and a monitor compares them against the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_timing_gen;

   localparam int S_HCOUNT = 0, S_VCOUNT = 1, S_VPROM_A = 2, S_HBLANK = 3,
                  S_HSYNC = 4, S_VBLANK = 5, S_VSYNC = 6, S_VAUX = 7,
                  S_BLANK = 8, S_FRAME = 9, S_IRQ = 10;

   typedef struct {
      int    inst;
      int    sel;
      int    exp;
      string name;
   } chk_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   chk_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   done_a   = 0;
   bit   done_b   = 0;

   always #5 clk = ~clk;

   video_timing_if ifa ();
   video_timing_if ifb ();

   // PROM contents: vblank on 0xdc-0xfe, vsync on 0xe7-0xf2, aux on 0x5e
   function automatic logic [3:0] prom(input logic [7:0] a);
      return {1'b0, (a >= 8'hdc && a <= 8'hfe), (a >= 8'he7 && a <= 8'hf2), (a == 8'h5e)};
   endfunction

   assign ifa.vprom_d = prom(ifa.vprom_a);
   assign ifb.vprom_d = prom(ifb.vprom_a);

   video_timing_gen u_dut_a (
      .clk   (clk),
      .reset (rst_a),
      .vt    (ifa)
   );

   video_timing_gen #(
      .H_TOTAL       (40),
      .H_BLANK_START (24),
      .HSYNC_START   (28),
      .HSYNC_END     (32)
   ) u_dut_b (
      .clk   (clk),
      .reset (rst_b),
      .vt    (ifb)
   );

   task automatic push(input int inst, input int sel, input int e, input string nm);
      chk_t c;
      c.inst = inst;
      c.sel  = sel;
      c.exp  = e;
      c.name = nm;
      q.push_back(c);
   endtask

   task automatic push_reset(input int inst);
      push(inst, S_HCOUNT, 0, "rst_hcount");
      push(inst, S_VCOUNT, 0, "rst_vcount");
      push(inst, S_VPROM_A, 1, "rst_vprom_a");
      push(inst, S_HBLANK, 0, "rst_hblank");
      push(inst, S_HSYNC, 0, "rst_hsync");
      push(inst, S_VBLANK, 0, "rst_vblank");
      push(inst, S_VSYNC, 0, "rst_vsync");
      push(inst, S_VAUX, 0, "rst_vaux");
      push(inst, S_BLANK, 0, "rst_blank");
      push(inst, S_FRAME, 0, "rst_frame_start");
      push(inst, S_IRQ, 0, "rst_irq");
   endtask

   function automatic logic [31:0] pick(input int sel, input logic [8:0] h,
                                        input logic [7:0] v, input logic [7:0] pa,
                                        input logic [7:0] f);
      case (sel)
         S_HCOUNT:  return {23'd0, h};
         S_VCOUNT:  return {24'd0, v};
         S_VPROM_A: return {24'd0, pa};
         default:   return {31'd0, f[10 - sel]};
      endcase
   endfunction

   function automatic logic [31:0] actual(input int inst, input int sel);
      if (inst == 0)
         return pick(sel, ifa.hcount, ifa.vcount, ifa.vprom_a,
                     {ifa.hblank, ifa.hsync, ifa.vblank, ifa.vsync, ifa.vaux,
                      ifa.blank, ifa.frame_start, ifa.irq});
      return pick(sel, ifb.hcount, ifb.vcount, ifb.vprom_a,
                  {ifb.hblank, ifb.hsync, ifb.vblank, ifb.vsync, ifb.vaux,
                   ifb.blank, ifb.frame_start, ifb.irq});
   endfunction

   // Monitor: compare every pending expectation away from the active edge
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t        c;
         logic [31:0] a;
         c = q.pop_front();
         a = actual(c.inst, c.sel);
         n_checks++;
         if (a !== 32'(c.exp)) begin
            n_err++;
            $display("FAIL %s (inst %0d) at %0t: got %0h expected %0h",
                     c.name, c.inst, $time, a, c.exp);
         end
      end
   end

   // Instance A: default timing, ce=1 line, ce 1-of-4 line, mid-frame reset
   initial begin : stim_a
      int e;
      int hh;
      rst_a       = 1'b1;
      ifa.ce      = 1'b1;
      ifa.irq_ack = 1'b0;
      @(posedge clk); #1;
      push_reset(0);
      rst_a = 1'b0;
      for (int k = 1; k <= 383; k++) begin
         @(posedge clk); #1;
         push(0, S_HCOUNT, k, "a_hcount");
         push(0, S_HBLANK, int'(k >= 256), "a_hblank");
         push(0, S_HSYNC, int'(k >= 296 && k < 328), "a_hsync");
      end
      push(0, S_VCOUNT, 0, "a_vcount_before_wrap");
      push(0, S_FRAME, 0, "a_no_frame_start");
      @(posedge clk); #1;
      push(0, S_HCOUNT, 0, "a_hcount_wrap");
      push(0, S_VCOUNT, 1, "a_vcount_wrap");
      push(0, S_HBLANK, 0, "a_hblank_wrap");
      push(0, S_VPROM_A, 2, "a_vprom_a_line1");
      e = 0;
      for (int i = 0; i < 1536; i++) begin
         ifa.ce = (i % 4 == 0);
         @(posedge clk); #1;
         if (i % 4 == 0) e++;
         hh = e % 384;
         push(0, S_HCOUNT, hh, "a_ce4_hcount");
         push(0, S_VCOUNT, 1 + e / 384, "a_ce4_vcount");
         push(0, S_HBLANK, int'(hh >= 256), "a_ce4_hblank");
         push(0, S_HSYNC, int'(hh >= 296 && hh < 328), "a_ce4_hsync");
      end
      ifa.ce = 1'b1;
      repeat ((8'h90 - 2) * 384 + 100) @(posedge clk);
      #1;
      push(0, S_VCOUNT, 8'h90, "a_ff_vcount");
      push(0, S_HCOUNT, 100, "a_ff_hcount");
      push(0, S_IRQ, 1, "a_irq_held");
      rst_a = 1'b1;
      @(posedge clk); #1;
      push_reset(0);
      rst_a = 1'b0;
      @(posedge clk); #1;
      push(0, S_HCOUNT, 1, "a_restart_hcount");
      push(0, S_VCOUNT, 0, "a_restart_vcount");
      done_a = 1;
   end

   // Instance B: whole frame on a 40-column line, ce idle one clock in five
   initial begin : stim_b
      int h, v, nv, frame, cyc;
      bit irq_m, vb, vs, va, ce_b, ack_b, first, seen80;
      rst_b       = 1'b1;
      ifb.ce      = 1'b1;
      ifb.irq_ack = 1'b0;
      @(posedge clk); #1;
      push_reset(1);
      rst_b = 1'b0;
      h = 0; v = 0; frame = 0; cyc = 0;
      irq_m = 0; vb = 0; vs = 0; va = 0; first = 0; seen80 = 0;
      while (!(frame == 1 && v == 2)) begin
         if (cyc >= 20000) begin
            n_err++;
            $display("FAIL b_frame_timeout: got cycle %0d required frame end", cyc);
            break;
         end
         ce_b  = (cyc % 5 != 4);
         ack_b = (v == 8'h41 && h == 5) || (v == 8'h7f && h == 39) ||
                 (v == 8'h80 && h == 0) || (v == 8'hc1 && h == 5) ||
                 (v == 8'h10 && h == 3);
         ifb.ce      = ce_b;
         ifb.irq_ack = ack_b;
         push(1, S_HCOUNT, h, "b_hcount");
         push(1, S_VCOUNT, v, "b_vcount");
         push(1, S_VPROM_A, (v + 1) % 256, "b_vprom_a");
         push(1, S_HBLANK, int'(h >= 24), "b_hblank");
         push(1, S_HSYNC, int'(h >= 28 && h < 32), "b_hsync");
         push(1, S_VBLANK, vb, "b_vblank");
         push(1, S_VSYNC, vs, "b_vsync");
         push(1, S_VAUX, va, "b_vaux");
         push(1, S_BLANK, int'(h >= 24 || vb), "b_blank");
         push(1, S_FRAME, int'(ce_b && h == 39 && v == 255), "b_frame_start");
         push(1, S_IRQ, irq_m, "b_irq");
         if (first) begin
            case (v)
               8'hdb: push(1, S_VBLANK, 0, "vblank_line_db");
               8'hdc: push(1, S_VBLANK, 1, "vblank_rise_dc");
               8'hfe: push(1, S_VBLANK, 1, "vblank_line_fe");
               8'hff: push(1, S_VBLANK, 0, "vblank_fall_ff");
               8'he6: push(1, S_VSYNC, 0, "vsync_line_e6");
               8'he7: push(1, S_VSYNC, 1, "vsync_rise_e7");
               8'hf2: push(1, S_VSYNC, 1, "vsync_line_f2");
               8'hf3: push(1, S_VSYNC, 0, "vsync_fall_f3");
               8'h5d: push(1, S_VAUX, 0, "vaux_line_5d");
               8'h5e: push(1, S_VAUX, 1, "vaux_line_5e");
               8'h5f: push(1, S_VAUX, 0, "vaux_line_5f");
               8'h40: push(1, S_IRQ, 1, "irq_set_40");
               8'h80: push(1, S_IRQ, 1, "irq_set_wins_80");
               8'hc0: push(1, S_IRQ, 1, "irq_set_c0");
               8'h00: begin
                  push(1, S_IRQ, 1, "irq_set_00");
                  push(1, S_VPROM_A, 1, "vprom_a_after_frame");
               end
               default: ;
            endcase
         end else if (v == 8'h80 && !seen80) begin
            seen80 = 1;
            push(1, S_IRQ, 0, "irq_ack_clears_80");
         end
         @(posedge clk); #1;
         nv = (v + 1) % 256;
         if (ce_b && h == 39 && nv % 64 == 0) irq_m = 1;
         else if (ack_b) irq_m = 0;
         first = 0;
         if (ce_b) begin
            if (h == 39) begin
               h = 0;
               v = nv;
               if (v == 0) frame++;
               vb = (v >= 8'hdc && v <= 8'hfe);
               vs = (v >= 8'he7 && v <= 8'hf2);
               va = (v == 8'h5e);
               first = 1;
            end else begin
               h++;
            end
         end
         cyc++;
      end
      done_b = 1;
   end

   // Wait for both streams (bounded), drain the queue, report
   initial begin : finish_blk
      fork
         wait (done_a && done_b);
         #(800_000);
      join_any
      disable fork;
      if (!(done_a && done_b)) begin
         n_err++;
         $display("FAIL run_timeout: got done_a=%0d done_b=%0d required 1 1", done_a, done_b);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Horizontal/vertical raster timing generator that sits directly upstream of the vertical sync PROM (256x4).
- Drives the PROM address from its line counter, then registers the PROM's 4-bit output so vblank/vsync align with the line they describe.
- Also produces hcount, hblank, hsync, composite blank, frame_start and a line-based CPU interrupt request with acknowledge.
- Downstream consumers are the playfield/motion-object pipelines and the video output mux.

Parameters:
- H_TOTAL, 384: pixel clocks per line; hcount runs 0..H_TOTAL-1.
- H_BLANK_START, 256: first hcount of hblank; blank continues to end of line.
- HSYNC_START, 296: first hcount with hsync high.
- HSYNC_END, 328: first hcount after hsync; range is [HSYNC_START, HSYNC_END).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  pixel clock enable; all counters and timing registers advance only when ce=1.
- vprom_a  out  8  PROM address = (vcount+1) mod 256, combinational from vcount.
- vprom_d  in  4  PROM data, combinational from vprom_a. Bit [2]=vblank, [1]=vsync, [0]=aux.
- hcount  out  9  current pixel column.
- vcount  out  8  current line.
- hblank  out  1  registered.
- hsync  out  1  registered, active high.
- vblank  out  1  latched vprom_d[2].
- vsync  out  1  latched vprom_d[1].
- vaux  out  1  latched vprom_d[0], passed through raw.
- blank  out  1  hblank | vblank.
- frame_start  out  1  one-clk pulse.
- irq  out  1  level interrupt request.
- irq_ack  in  1  clears irq.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset, sampled at posedge clk, and overrides ce.
- Reset values: hcount=0, vcount=0, hblank=0, hsync=0, vblank=0, vsync=0, vaux=0, blank=0, frame_start=0, irq=0.
- ce=0: every register holds. frame_start is forced 0. irq_ack is still honoured.
- Horizontal, on ce:
  - hcount increments.
  - At hcount==H_TOTAL-1 it wraps to 0 ("line wrap").
- hblank and hsync are registered from the next hcount value, so they are aligned with hcount in the same cycle (zero latency).
- Vertical, on line wrap:
  - vcount increments mod 256 (0xff->0x00, no reload).
  - In the same cycle, vblank/vsync/vaux latch vprom_d, which was addressed by vcount+1. The latched values therefore belong to the new vcount.
  - Latched values are held for the whole line.
- blank is combinational OR of the registered hblank and vblank.
- frame_start: high for exactly one clk, on the ce cycle where a line wrap takes vcount from 0xff to 0x00.
- irq:
  - Set on a line wrap whose new vcount[5:0]==0, i.e. lines 0x00, 0x40, 0x80, 0xc0 (4 per frame).
  - Cleared on irq_ack=1.
  - If set and ack occur in the same cycle, set wins.
  - Ack while irq is already 0 has no effect.
- Reset mid-line or mid-frame: the next cycle shows reset values. The raster restarts at (0,0) on the first ce after reset deasserts.
- Widths:
  - hcount is 9 bits; H_TOTAL must be <= 512, checked at elaboration.
  - vprom_a addition truncates to 8 bits, so vcount=0xff drives vprom_a=0x00.

Decomposition:
- Shared package video_timing_pkg holds:
  - default H_TOTAL, H_BLANK_START, HSYNC_START, HSYNC_END;
  - PROM bit indices VPROM_VBLANK=2, VPROM_VSYNC=1, VPROM_AUX=0;
  - IRQ_LINE_MASK=6'h3f.
- One sub-module, video_hcounter, holds the hcount/hblank/hsync registers and emits a line_wrap strobe.
- The top module holds vcount, PROM latch, frame_start and irq.

Test Plan:
- Reset then 383 ce cycles -> hcount=383, vcount=0. Next ce -> hcount=0, vcount=1.
- ce toggled 1-of-4 -> line length is 1536 clk. hblank asserts at hcount 256. hsync is high for hcount 296..327 only.
- PROM model (0xdc-0xfe bit2, 0xe7-0xf2 bit1, 0x5e bit0) -> vblank rises when vcount becomes 0xdc and falls at 0xff. vsync is high for lines 0xe7..0xf2 (12 lines). vaux is high only on line 0x5e.
- Run to vcount=0xff end of line -> vcount=0x00, frame_start is a single-clk pulse, vprom_a=0x01 afterwards.
- irq -> rises on entry to lines 0x40, 0x80, 0xc0, 0x00. irq_ack asserted on the same cycle as the 0x80 set leaves irq=1. irq_ack a cycle later gives irq=0.
- reset asserted at vcount=0x90, hcount=100 with ce=1 -> next cycle all outputs are at reset values and vprom_a=0x01.
